mfp_ahb_gpio_out_bank: RTL

//  AHB-Lite slave with NUM_PORTS output ports of PORT_W bits each, on the mfp AHB-Lite matrix.

---
 rtl/mfp_ahb_gpio_out_bank.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mfp_ahb_gpio_out_bank.sv
// mfp_ahb_gpio_out_bank: AHB-Lite output port bank with DATA/SET/CLR/TOG registers and optional PULSE (MFP_GPIO_OUT_PULSE_EN)
module mfp_ahb_gpio_out_bank #(
   parameter int                NUM_PORTS    = 4,
   parameter int                PORT_W       = 16,
   parameter logic [PORT_W-1:0] RESET_VAL    = '0,
   parameter logic [15:0]       PULSE_CYCLES = 16'd8
) (
   input  logic                        HCLK,
   input  logic                        HRESET,
   input  logic [31:0]                 HADDR,
   input  logic [2:0]                  HBURST,
   input  logic                        HMASTLOCK,
   input  logic [3:0]                  HPROT,
   input  logic [2:0]                  HSIZE,
   input  logic                        HSEL,
   input  logic [1:0]                  HTRANS,
   input  logic [31:0]                 HWDATA,
   input  logic                        HWRITE,
   output logic [31:0]                 HRDATA,
   output logic                        HREADY,
   output logic                        HRESP,
   input  logic                        SI_Endian,
   output logic [NUM_PORTS*PORT_W-1:0] port_out
);
   logic                valid_q, write_q;
   logic [7:0]          addr_q;
   logic [2:0]          size_q;
   logic [3:0]          lanes;
   logic [31:0]         lmask;
   logic [PORT_W-1:0]   wm, rd;
   logic [2:0]          psel, rsel;
   logic                wr;
   logic [NUM_PORTS-1:0] hit;
   logic [PORT_W-1:0]   d_q [NUM_PORTS];
   logic [PORT_W-1:0]   d_d [NUM_PORTS];
   logic [PORT_W-1:0]   pm  [NUM_PORTS];
   logic                unused;

   assign HREADY = 1'b1;
   assign HRESP  = 1'b0;
   assign unused = ^{HBURST, HMASTLOCK, HPROT, SI_Endian, HADDR[31:8], HTRANS[0], HWDATA, lmask};
   assign psel   = addr_q[7:5];
   assign rsel   = addr_q[4:2];
   assign wr     = valid_q && write_q;

   // capture the address phase; reset discards any transfer in flight
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         valid_q <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= '0;
         size_q  <= '0;
      end else begin
         valid_q <= HSEL && HTRANS[1];
         write_q <= HWRITE;
         addr_q  <= HADDR[7:0];
         size_q  <= HSIZE;
      end
   end

   // byte-lane mask from captured size/address, masked write data and per-port hit
   always_comb begin
      lanes = (size_q == 3'd0) ? (4'b0001 << addr_q[1:0]) :
              (size_q == 3'd1) ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      lmask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
      wm    = HWDATA[PORT_W-1:0] & lmask[PORT_W-1:0];
      hit   = '0;
      for (int p = 0; p < NUM_PORTS; p++) hit[p] = wr && (32'(psel) == p);
   end

   // next DATA value for each port
   always_comb begin
      d_d = d_q;
      for (int p = 0; p < NUM_PORTS; p++)
         d_d[p] = !hit[p]       ? d_q[p] :
                  rsel == 3'd0  ? (d_q[p] & ~lmask[PORT_W-1:0]) | wm :
                  rsel == 3'd1  ? d_q[p] | wm :
                  rsel == 3'd2  ? d_q[p] & ~wm :
                  rsel == 3'd3  ? d_q[p] ^ wm : d_q[p];
   end

   // DATA registers
   always_ff @(posedge HCLK) begin
      if (HRESET) for (int p = 0; p < NUM_PORTS; p++) d_q[p] <= RESET_VAL;
      else d_q <= d_d;
   end

`ifdef MFP_GPIO_OUT_PULSE_EN
   logic [PORT_W-1:0] pm_q [NUM_PORTS];
   logic [15:0]       c_q  [NUM_PORTS];

   // pulse mask and down-counter per port; a non-zero write retriggers all active bits
   always_ff @(posedge HCLK) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (HRESET) begin
            pm_q[p] <= '0;
            c_q[p]  <= '0;
         end else if (hit[p] && rsel == 3'd4 && wm != '0) begin
            pm_q[p] <= pm_q[p] | wm;
            c_q[p]  <= PULSE_CYCLES;
         end else if (c_q[p] != 16'd0) begin
            c_q[p] <= c_q[p] - 16'd1;
            if (c_q[p] == 16'd1) pm_q[p] <= '0;
         end
      end
   end

   // expose the pulse mask
   always_comb begin
      pm = pm_q;
   end
`else
   // no pulse hardware: mask is constant zero
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) pm[p] = '0;
   end
`endif

   // read mux from the captured address, zero for writes, idle and holes
   always_comb begin
      rd = '0;
      for (int p = 0; p < NUM_PORTS; p++)
         if (32'(psel) == p) rd = rsel <= 3'd3 ? d_q[p] : rsel == 3'd4 ? pm[p] : '0;
      HRDATA = (valid_q && !write_q) ? 32'(rd) : 32'h0;
   end

   genvar g;
   generate
      for (g = 0; g < NUM_PORTS; g++) begin : g_out
         assign port_out[g*PORT_W +: PORT_W] = d_q[g] | pm[g];
      end
   endgenerate
endmodule
